// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: character LCD (HD44780-style, 8-bit bus) text controller.
// Keeps a ROWS*COLS text buffer, runs the power-up init sequence, repaints
// the panel whenever the buffer changes and can scroll the display
// continuously. Every bus byte spans three ticks: setup, strobe, hold.
module lcd_text_ctrl #(
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int CLK_DIV     = 5,
  parameter int POWER_TICKS = 70,
  parameter int LONG_TICKS  = 200,
  parameter int SHIFT_TICKS = 50
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WR_EN,
  input  logic [5:0] WR_ADDR,
  input  logic [7:0] WR_DATA,
  input  logic       SHIFT_EN,
  input  logic       SHIFT_DIR,
  output logic       BUSY,
  output logic       INIT_DONE,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NSLOT = 1 << AW;

  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_FUNC,
    S_DISP,
    S_ENTRY,
    S_CLEAR,
    S_HOME,
    S_LONG_WAIT,
    S_ROW_CMD,
    S_ROW_DATA,
    S_SHIFT,
    S_IDLE
  } state_t;

  // States that put one byte on the bus (three ticks each).
  function automatic logic is_byte_state(input state_t s);
    case (s)
      S_FUNC, S_DISP, S_ENTRY, S_CLEAR, S_HOME,
      S_ROW_CMD, S_ROW_DATA, S_SHIFT: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Registered state
  state_t          state_r;
  logic [1:0]      phase_r;
  logic [15:0]     tick_cnt_r;
  logic [15:0]     wait_r;
  logic [15:0]     shift_cnt_r;
  logic            row_r;
  logic [5:0]      col_r;
  logic [AW-1:0]   idx_r;
  logic            dirty_r;
  logic            init_done_r;
  logic            busy_r;
  logic            lcd_e_r;
  logic            lcd_rs_r;
  logic [7:0]      lcd_data_r;
  logic [7:0]      text_r [0:NSLOT-1];

  // Next-state / decoded signals
  state_t          state_n;
  logic [1:0]      phase_n;
  logic [15:0]     wait_n;
  logic [15:0]     shift_cnt_n;
  logic            row_n;
  logic [5:0]      col_n;
  logic [AW-1:0]   idx_n;
  logic            dirty_clr_s;
  logic            done_set_s;
  logic            tick_s;
  logic            last_phase_s;
  logic            wr_ok_s;
  logic [AW-1:0]   wr_idx_s;
  logic [7:0]      out_byte_s;
  logic            out_rs_s;

  assign tick_s       = (tick_cnt_r == 16'(CLK_DIV - 1));
  assign last_phase_s = (phase_r == 2'd2);
  assign wr_ok_s      = WR_EN && (int'(WR_ADDR) < DEPTH);
  assign wr_idx_s     = AW'(WR_ADDR);

  assign BUSY      = busy_r;
  assign INIT_DONE = init_done_r;
  assign LCD_E     = lcd_e_r;
  assign LCD_RS    = lcd_rs_r;
  assign LCD_RW    = 1'b0;
  assign LCD_DATA  = lcd_data_r;

  // Free-running tick divider, restarted by reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tick_cnt_r <= 16'd0;
    end else if (tick_s) begin
      tick_cnt_r <= 16'd0;
    end else begin
      tick_cnt_r <= tick_cnt_r + 16'd1;
    end
  end

  // Text buffer: writes land immediately in any state; reset paints spaces.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NSLOT; i++) begin
        text_r[i] <= 8'h20;
      end
    end else if (wr_ok_s) begin
      text_r[wr_idx_s] <= WR_DATA;
    end
  end

  // Dirty flag: a new write wins over the clear so no change is ever lost.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dirty_r <= 1'b0;
    end else if (wr_ok_s) begin
      dirty_r <= 1'b1;
    end else if (dirty_clr_s) begin
      dirty_r <= 1'b0;
    end else begin
      dirty_r <= dirty_r;
    end
  end

  // Sequencer state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= S_PWR_WAIT;
      phase_r     <= 2'd0;
      wait_r      <= 16'd0;
      shift_cnt_r <= 16'd0;
      row_r       <= 1'b0;
      col_r       <= 6'd0;
      idx_r       <= {AW{1'b0}};
    end else begin
      state_r     <= state_n;
      phase_r     <= phase_n;
      wait_r      <= wait_n;
      shift_cnt_r <= shift_cnt_n;
      row_r       <= row_n;
      col_r       <= col_n;
      idx_r       <= idx_n;
    end
  end

  // Next-state logic; everything moves on tick only.
  always_comb begin
    state_n     = state_r;
    phase_n     = phase_r;
    wait_n      = wait_r;
    shift_cnt_n = shift_cnt_r;
    row_n       = row_r;
    col_n       = col_r;
    idx_n       = idx_r;
    dirty_clr_s = 1'b0;
    done_set_s  = 1'b0;
    if (tick_s) begin
      if (is_byte_state(state_r)) begin
        phase_n = last_phase_s ? 2'd0 : phase_r + 2'd1;
      end else begin
        phase_n = 2'd0;
      end
      case (state_r)
        S_PWR_WAIT: begin
          if (int'(wait_r) + 1 >= POWER_TICKS) begin
            state_n = S_FUNC;
            wait_n  = 16'd0;
          end else begin
            wait_n  = wait_r + 16'd1;
          end
        end
        S_FUNC:  state_n = last_phase_s ? S_DISP  : S_FUNC;
        S_DISP:  state_n = last_phase_s ? S_ENTRY : S_DISP;
        S_ENTRY: state_n = last_phase_s ? S_CLEAR : S_ENTRY;
        S_CLEAR, S_HOME: begin
          if (last_phase_s) begin
            state_n = S_LONG_WAIT;
            wait_n  = 16'd0;
          end else begin
            state_n = state_r;
          end
        end
        S_LONG_WAIT: begin
          if (int'(wait_r) + 1 >= LONG_TICKS) begin
            state_n = S_ROW_CMD;
            wait_n  = 16'd0;
            row_n   = 1'b0;
          end else begin
            wait_n  = wait_r + 16'd1;
          end
        end
        S_ROW_CMD: begin
          if (last_phase_s) begin
            state_n = S_ROW_DATA;
            col_n   = 6'd0;
            idx_n   = row_r ? AW'(COLS) : {AW{1'b0}};
          end else begin
            state_n = S_ROW_CMD;
          end
        end
        S_ROW_DATA: begin
          if (!last_phase_s) begin
            state_n = S_ROW_DATA;
          end else if (col_r != 6'(COLS - 1)) begin
            col_n = col_r + 6'd1;
            idx_n = idx_r + {{(AW-1){1'b0}}, 1'b1};
          end else if (int'(row_r) == ROWS - 1) begin
            state_n     = S_IDLE;
            shift_cnt_n = 16'd0;
            done_set_s  = 1'b1;
          end else begin
            state_n = S_ROW_CMD;
            row_n   = 1'b1;
          end
        end
        S_SHIFT: begin
          if (last_phase_s) begin
            state_n     = S_IDLE;
            shift_cnt_n = 16'd0;
          end else begin
            state_n = S_SHIFT;
          end
        end
        S_IDLE: begin
          // A pending repaint outranks a shift due on the same tick.
          if (dirty_r) begin
            state_n     = S_HOME;
            dirty_clr_s = 1'b1;
            shift_cnt_n = 16'd0;
          end else if (SHIFT_EN) begin
            if (int'(shift_cnt_r) + 1 >= SHIFT_TICKS) begin
              state_n     = S_SHIFT;
              shift_cnt_n = 16'd0;
            end else begin
              shift_cnt_n = shift_cnt_r + 16'd1;
            end
          end else begin
            shift_cnt_n = 16'd0;
          end
        end
        default: begin
          state_n = S_PWR_WAIT;
          phase_n = 2'd0;
          wait_n  = 16'd0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Byte that the upcoming state places on the bus.
  always_comb begin
    out_byte_s = 8'h00;
    out_rs_s   = 1'b0;
    case (state_n)
      S_FUNC:     out_byte_s = (ROWS == 2) ? 8'h38 : 8'h30;
      S_DISP:     out_byte_s = 8'h0C;
      S_ENTRY:    out_byte_s = 8'h06;
      S_CLEAR:    out_byte_s = 8'h01;
      S_HOME:     out_byte_s = 8'h02;
      S_ROW_CMD:  out_byte_s = row_n ? 8'hC0 : 8'h80;
      S_ROW_DATA: begin
        out_byte_s = text_r[idx_n];
        out_rs_s   = 1'b1;
      end
      S_SHIFT:    out_byte_s = SHIFT_DIR ? 8'h1C : 8'h18;
      default:    out_byte_s = 8'h00;
    endcase
  end

  // Registered bus and status; RS/DATA latch once per byte so later
  // buffer writes or SHIFT_DIR changes cannot disturb a byte in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lcd_e_r     <= 1'b0;
      lcd_rs_r    <= 1'b0;
      lcd_data_r  <= 8'h00;
      busy_r      <= 1'b1;
      init_done_r <= 1'b0;
    end else begin
      busy_r <= (state_n != S_IDLE);
      if (done_set_s) begin
        init_done_r <= 1'b1;
      end
      if (tick_s) begin
        lcd_e_r <= is_byte_state(state_n) && (phase_n == 2'd1);
        if (is_byte_state(state_n) && (phase_n == 2'd0)) begin
          lcd_rs_r   <= out_rs_s;
          lcd_data_r <= out_byte_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Scoreboard bench for lcd_text_ctrl: stimulus pushes expected {RS,DATA}
// bytes, a negedge monitor pops one per LCD_E rising edge and also checks
// setup time and strobe width.
module tb_lcd_text_ctrl;
  localparam int CLK_DIV = 2;
  localparam int BUDGET  = 3000;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       WR_EN = 1'b0;
  logic [5:0] WR_ADDR = 6'd0;
  logic [7:0] WR_DATA = 8'd0;
  logic       SHIFT_EN = 1'b0;
  logic       SHIFT_DIR = 1'b0;
  logic       BUSY, INIT_DONE, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  int checks = 0;
  int failures = 0;
  logic [8:0] sb[$];

  lcd_text_ctrl #(
    .COLS(4), .ROWS(2), .CLK_DIV(CLK_DIV), .POWER_TICKS(4),
    .LONG_TICKS(3), .SHIFT_TICKS(5)
  ) dut (
    .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .SHIFT_EN(SHIFT_EN), .SHIFT_DIR(SHIFT_DIR),
    .BUSY(BUSY), .INIT_DONE(INIT_DONE), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic rs, input logic [7:0] d);
    sb.push_back({rs, d});
  endtask

  task automatic push_refresh(input logic [7:0] first, input logic [31:0] r0, input logic [31:0] r1);
    push(1'b0, first);
    push(1'b0, 8'h80);
    for (int i = 0; i < 4; i++) push(1'b1, r0[31-8*i -: 8]);
    push(1'b0, 8'hC0);
    for (int i = 0; i < 4; i++) push(1'b1, r1[31-8*i -: 8]);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38);
    push(1'b0, 8'h0C);
    push(1'b0, 8'h06);
    push_refresh(8'h01, 32'h20202020, 32'h20202020);
  endtask

  // Called at a negedge; write is sampled on the following posedge.
  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!(!BUSY && INIT_DONE && sb.size() == 0) && n < BUDGET) begin
      @(negedge CLK); n++;
    end
    check(nm, 32'(n < BUDGET), 32'd1);
  endtask

  task automatic wait_queue(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < BUDGET) begin
      @(negedge CLK); n++;
    end
    check(nm, 32'(n < BUDGET), 32'd1);
  endtask

  // Monitor state
  logic       prev_e = 1'b0;
  logic [8:0] prev_bus = 9'd0;
  logic [8:0] exp_bus;
  int stab = 0, hi = 0, cyc = 0, rise_prev = 0, rise_last = 0;

  // Byte monitor: pops and compares on every strobe rising edge.
  always @(negedge CLK) begin
    cyc++;
    if ({LCD_RS, LCD_DATA} != prev_bus) stab = 0; else stab++;
    prev_bus = {LCD_RS, LCD_DATA};
    if (LCD_E && !prev_e) begin
      hi = 1;
      rise_prev = rise_last;
      rise_last = cyc;
      check("setup_time", 32'(stab >= CLK_DIV), 32'd1);
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_byte: got %0h expected none", {LCD_RS, LCD_DATA});
      end else begin
        exp_bus = sb.pop_front();
        check("lcd_byte", 32'({LCD_RS, LCD_DATA}), 32'(exp_bus));
      end
    end else if (LCD_E && prev_e) begin
      hi++;
    end else if (!LCD_E && prev_e && !RESET) begin
      check("strobe_width", 32'(hi), 32'(CLK_DIV));
    end
    prev_e = LCD_E;
  end

  initial begin
    int n;
    int busy_seen;
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_e", 32'(LCD_E), 32'd0);
    check("rst_rs", 32'(LCD_RS), 32'd0);
    check("rst_rw", 32'(LCD_RW), 32'd0);
    check("rst_data", 32'(LCD_DATA), 32'h00);
    check("rst_busy", 32'(BUSY), 32'd1);
    check("rst_init_done", 32'(INIT_DONE), 32'd0);
    @(negedge CLK);
    push_init();
    RESET = 1'b0;
    wait_idle("init_complete");
    check("init_done", 32'(INIT_DONE), 32'd1);
    check("init_busy", 32'(BUSY), 32'd0);

    // In-range write triggers return-home and repaint
    push_refresh(8'h02, 32'h20202020, 32'h20412020);
    do_write(6'd5, 8'h41);
    wait_idle("write5_refresh");
    check("write5_busy", 32'(BUSY), 32'd0);

    // Out-of-range write is ignored
    do_write(6'd8, 8'h55);
    busy_seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (BUSY) busy_seen++;
    end
    check("oob_no_busy", 32'(busy_seen), 32'd0);

    // Continuous left shift, spacing = SHIFT_TICKS + 3 ticks = 16 cycles
    SHIFT_DIR = 1'b0;
    SHIFT_EN = 1'b1;
    push(1'b0, 8'h18);
    push(1'b0, 8'h18);
    wait_queue("shift_pair");
    check("shift_period", 32'(rise_last - rise_prev), 32'd16);
    n = 0;
    while (BUSY && n < BUDGET) begin @(negedge CLK); n++; end
    check("shift_done", 32'(n < BUDGET), 32'd1);
    // Write lands just before the tick on which the next shift is due
    push_refresh(8'h02, 32'h42202020, 32'h20412020);
    push(1'b0, 8'h18);
    repeat (8) @(negedge CLK);
    do_write(6'd0, 8'h42);
    wait_queue("refresh_before_shift");
    SHIFT_EN = 1'b0;
    wait_idle("shift_stop");

    // Right shift
    SHIFT_DIR = 1'b1;
    SHIFT_EN = 1'b1;
    push(1'b0, 8'h1C);
    wait_queue("shift_right");
    SHIFT_EN = 1'b0;
    SHIFT_DIR = 1'b0;
    wait_idle("shift_right_idle");

    // Reset during strobe of a data byte
    push(1'b0, 8'h02);
    push(1'b0, 8'h80);
    push(1'b1, 8'h42);
    do_write(6'd2, 8'h55);
    n = 0;
    while (!(LCD_E && LCD_RS) && n < BUDGET) begin @(negedge CLK); n++; end
    check("data_strobe_seen", 32'(n < BUDGET), 32'd1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_e_low", 32'(LCD_E), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd1);
    check("abort_init_done", 32'(INIT_DONE), 32'd0);
    check("abort_queue", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    push_init();
    RESET = 1'b0;
    wait_idle("reinit_complete");
    check("reinit_done", 32'(INIT_DONE), 32'd1);
    check("reinit_busy", 32'(BUSY), 32'd0);
    check("reinit_rw", 32'(LCD_RW), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
